// File: rtl/alu_cmd_issuer.sv
// Command FIFO feeding a fixed-latency external ALU: pops one command at a time,
// waits ALU_LAT cycles, captures the result and holds it until the consumer takes it.
module alu_cmd_issuer #(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_op,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    output logic [9:0] alu_cmd,
    input  logic [9:0] alu_res,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [9:0] out_res,
    output logic [9:0] out_cmd,
    output logic       busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t          state_q, state_d;
    logic [9:0]      mem_q [DEPTH];
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [3:0]      lat_q, lat_d;
    logic [9:0]      cmd_q, cmd_d;
    logic [9:0]      res_q, res_d;
    logic [9:0]      ocmd_q, ocmd_d;
    logic            ovld_q, ovld_d;
    logic            push, pop;

    // Ready comes only from the registered count so it never depends on this cycle's pop.
    assign in_ready  = (count_q != CW'(DEPTH));
    assign push      = in_valid && in_ready;
    assign alu_cmd   = cmd_q;
    assign out_valid = ovld_q;
    assign out_res   = res_q;
    assign out_cmd   = ocmd_q;
    assign busy      = (state_q != IDLE) || (count_q != '0);

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        cmd_d   = cmd_q;
        res_d   = res_q;
        ocmd_d  = ocmd_q;
        ovld_d  = ovld_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    cmd_d   = mem_q[rptr_q];
                    lat_d   = 4'(ALU_LAT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (lat_q == 4'd1) begin
                    res_d   = alu_res;
                    ocmd_d  = cmd_q;
                    ovld_d  = 1'b1;
                    lat_d   = 4'd0;
                    state_d = HOLD;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    ovld_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_comb begin
        wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
        rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= {in_op, in_b, in_a};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            lat_q   <= '0;
            cmd_q   <= '0;
            res_q   <= '0;
            ocmd_q  <= '0;
            ovld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            lat_q   <= lat_d;
            cmd_q   <= cmd_d;
            res_q   <= res_d;
            ocmd_q  <= ocmd_d;
            ovld_q  <= ovld_d;
        end
    end

endmodule
